// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream reader and its 2-entry stream FIFO.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam int FIFO_DEPTH = 2;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int FIFO_CNT_W = count_width(FIFO_DEPTH);

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO; the head entry is presented combinationally on head_o.
module stream_fifo2
    import ram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [FIFO_CNT_W-1:0] count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: storage is reset on purpose so the head reads 0 instead of X out of reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + FIFO_CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - FIFO_CNT_W'(1);
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));

endmodule

// File: rtl/ram_stream_reader.sv
// Sweeps a contiguous RAM address range and streams the words out on valid/ready,
// hiding the RAM's one-cycle read latency behind a 2-entry FIFO.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] startAddr,
    input  logic [ADDRESS_WIDTH:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic                     memWEn,
    output logic [ADDRESS_WIDTH-1:0] memAddr,
    input  logic [DATA_WIDTH-1:0]    memDataOut,
    output logic [DATA_WIDTH-1:0]    outData,
    output logic                     outValid,
    input  logic                     outReady
);

    localparam int CNT_W = ADDRESS_WIDTH + 1;
    localparam int OCC_W = FIFO_CNT_W + 1;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]         len_q, len_d;
    logic [CNT_W-1:0]         issued_q, issued_d;
    logic [CNT_W-1:0]         popped_q, popped_d;
    logic                     in_flight_q, in_flight_d;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  pop;
    logic                  issue;
    logic [OCC_W-1:0]      occ_after_pop;

    assign pop      = !fifo_empty && outReady;
    assign outValid = !fifo_empty;
    assign memWEn   = 1'b0;
    assign memAddr  = addr_q;

    // Words already owed to the FIFO once this cycle's pop is taken; a new read needs a free slot.
    assign occ_after_pop = {1'b0, fifo_count} + OCC_W'(in_flight_q) - OCC_W'(pop);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        popped_d    = popped_q;
        in_flight_d = 1'b0;
        issue       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = startAddr;
                    len_d    = length;
                    issued_d = '0;
                    popped_d = '0;
                    state_d  = (length == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                issue = (issued_q < len_q) && (occ_after_pop < OCC_W'(FIFO_DEPTH));
                if (issue) begin
                    in_flight_d = 1'b1;
                    issued_d    = issued_q + CNT_W'(1);
                    addr_d      = addr_q + ADDRESS_WIDTH'(1);
                end
                if (pop) begin
                    popped_d = popped_q + CNT_W'(1);
                    if (popped_d == len_q) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            in_flight_q <= in_flight_d;
        end
    end

    stream_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (in_flight_q),
        .data_i  (memDataOut),
        .pop_i   (pop),
        .head_o  (outData),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // The issue rule guarantees a free slot whenever a read lands.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(in_flight_q && fifo_full));

endmodule
